axi4_burst_slave: RTL

//  AXI4 full slave backed by on-chip byte-writable RAM; parametrised successor of the simple INCR-only slave.

---
 rtl/axi4_burst_pkg.sv | 28 ++
 rtl/axi4_burst_slave_mem.sv | 31 +++
 rtl/axi4_burst_slave.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_pkg.sv
// axi4_burst_pkg: shared types for the AXI4 burst slave.
//   burst_t / resp_t        : AXI burst and response encodings
//   wstate_t / rstate_t     : write and read channel FSM states
//   next_addr()             : beat-to-beat word address step (FIXED/INCR/WRAP)
package axi4_burst_pkg;

   typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_t;
   typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

   // Word address of the following beat. Computed at 32 bits; the caller
   // truncates to the RAM word-address width, which gives INCR its
   // wrap-modulo-depth behaviour for free. WRAP keeps the bits above the
   // wrap mask (len) and increments only inside it.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [7:0]  len,
                                             input logic [1:0]  burst);
      logic [31:0] mask;
      mask = {24'd0, len};
      case (burst)
         FIXED:   next_addr = addr;
         WRAP:    next_addr = (addr & ~mask) | ((addr + 32'd1) & mask);
         default: next_addr = addr + 32'd1;
      endcase
   endfunction

endpackage

// File: rtl/axi4_burst_slave_mem.sv
// axi4_burst_slave_mem: simple dual-port RAM, per-byte write enable,
// one-cycle registered read, read-before-write on address collision.
//   clock  : rising-edge clock
//   we     : byte write enables (one per data byte)
//   waddr  : write word address        wdata : write data
//   raddr  : read word address         rdata : registered read data
module axi4_burst_slave_mem #(
   parameter int    AW        = 4,
   parameter int    DW        = 32,
   parameter string INIT_FILE = ""
) (
   input  logic            clock,
   input  logic [DW/8-1:0] we,
   input  logic [AW-1:0]   waddr,
   input  logic [DW-1:0]   wdata,
   input  logic [AW-1:0]   raddr,
   output logic [DW-1:0]   rdata
);

   logic [DW-1:0] mem [2**AW];

   // Read samples the array before this edge's writes land, so a same-word
   // collision returns the old contents.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DW/8; i++) begin
         if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi4_burst_slave.sv
// axi4_burst_slave: AXI4 slave backed by byte-writable on-chip RAM.
// FIXED/INCR/WRAP bursts, byte strobes, SLVERR reporting, one read beat per
// cycle. Read and write paths are independent FSMs sharing the RAM ports.
//   clock, reset            : clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*         : write address, write data, write response
//   s_ar*/s_r*              : read address, read data
//   s_*lock/cache/prot/qos  : accepted and ignored
module axi4_burst_slave
   import axi4_burst_pkg::*;
#(
   parameter int    G_ADDR_WIDTH  = 6,
   parameter int    G_DATA_WIDTH  = 32,
   parameter int    G_ID_WIDTH    = 2,
   parameter string MEM_INIT_FILE = ""
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      s_awready,
   input  logic                      s_awvalid,
   input  logic [G_ID_WIDTH-1:0]     s_awid,
   input  logic [G_ADDR_WIDTH-1:0]   s_awaddr,
   input  logic [7:0]                s_awlen,
   input  logic [2:0]                s_awsize,
   input  logic [1:0]                s_awburst,
   input  logic                      s_awlock,
   input  logic [3:0]                s_awcache,
   input  logic [2:0]                s_awprot,
   input  logic [3:0]                s_awqos,
   output logic                      s_wready,
   input  logic                      s_wvalid,
   input  logic [G_DATA_WIDTH-1:0]   s_wdata,
   input  logic [G_DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                      s_wlast,
   input  logic                      s_bready,
   output logic                      s_bvalid,
   output logic [G_ID_WIDTH-1:0]     s_bid,
   output logic [1:0]                s_bresp,
   output logic                      s_arready,
   input  logic                      s_arvalid,
   input  logic [G_ID_WIDTH-1:0]     s_arid,
   input  logic [G_ADDR_WIDTH-1:0]   s_araddr,
   input  logic [7:0]                s_arlen,
   input  logic [2:0]                s_arsize,
   input  logic [1:0]                s_arburst,
   input  logic                      s_arlock,
   input  logic [3:0]                s_arcache,
   input  logic [2:0]                s_arprot,
   input  logic [3:0]                s_arqos,
   input  logic                      s_rready,
   output logic                      s_rvalid,
   output logic [G_ID_WIDTH-1:0]     s_rid,
   output logic [G_DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rlast
);

   localparam int NB   = G_DATA_WIDTH / 8;
   localparam int OFST = $clog2(NB);
   localparam int WA   = G_ADDR_WIDTH - OFST;

   function automatic logic [WA-1:0] step(input logic [WA-1:0] a,
                                          input logic [7:0]    len,
                                          input logic [1:0]    burst);
      logic [31:0] n;
      n = next_addr(32'(a), len, burst);
      return n[WA-1:0];
   endfunction

   function automatic logic req_bad(input logic [2:0] size,
                                    input logic [1:0] burst,
                                    input logic [7:0] len);
      logic wrap_len_bad;
      wrap_len_bad = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      return (size != 3'(OFST)) || (burst == 2'b11) || (burst == WRAP && wrap_len_bad);
   endfunction

   // ---------------- write path ----------------
   wstate_t         wstate;
   logic [WA-1:0]   waddr;
   logic [7:0]      wlen, wcnt;
   logic [1:0]      wburst;
   logic [G_ID_WIDTH-1:0] wid;
   logic            werr_req;   // address-phase error: suppress all writes
   logic            werr_last;  // an earlier beat carried wlast too soon

   logic            w_hs, w_final;
   logic [NB-1:0]   mem_we;

   assign w_hs    = s_wvalid & s_wready;
   assign w_final = (wcnt == wlen);
   assign mem_we  = (w_hs && !werr_req) ? s_wstrb : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wstate    <= W_IDLE;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bid     <= '0;
         s_bresp   <= OKAY;
         waddr     <= '0;
         wlen      <= '0;
         wcnt      <= '0;
         wburst    <= '0;
         wid       <= '0;
         werr_req  <= 1'b0;
         werr_last <= 1'b0;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (s_awready && s_awvalid) begin
                  waddr     <= s_awaddr[G_ADDR_WIDTH-1:OFST];
                  wlen      <= s_awlen;
                  wburst    <= s_awburst;
                  wid       <= s_awid;
                  werr_req  <= req_bad(s_awsize, s_awburst, s_awlen);
                  werr_last <= 1'b0;
                  wcnt      <= '0;
                  s_awready <= 1'b0;
                  s_wready  <= 1'b1;
                  wstate    <= W_DATA;
               end else begin
                  s_awready <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  waddr <= step(waddr, wlen, wburst);
                  wcnt  <= wcnt + 8'd1;
                  if (w_final) begin
                     // A missing wlast on the final beat is folded in here.
                     s_wready <= 1'b0;
                     s_bvalid <= 1'b1;
                     s_bid    <= wid;
                     s_bresp  <= (werr_req || werr_last || !s_wlast) ? SLVERR : OKAY;
                     wstate   <= W_RESP;
                  end else if (s_wlast) begin
                     werr_last <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  s_awready <= 1'b1;
                  wstate    <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   // ---------------- read path ----------------
   rstate_t         rstate;
   logic [WA-1:0]   raddr;
   logic [7:0]      rlen, rcnt;
   logic [1:0]      rburst;
   logic            r_hs;
   logic [WA-1:0]   mem_raddr;

   assign r_hs = s_rvalid & s_rready;

   // The RAM output register is the rdata holding register: re-read the
   // current word while stalled, pre-fetch the next one on a handshake.
   always_comb begin
      mem_raddr = raddr;
      case (rstate)
         R_IDLE:  mem_raddr = s_araddr[G_ADDR_WIDTH-1:OFST];
         R_DATA:  if (r_hs) mem_raddr = step(raddr, rlen, rburst);
         default: mem_raddr = raddr;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rstate    <= R_IDLE;
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rid     <= '0;
         s_rresp   <= OKAY;
         s_rlast   <= 1'b0;
         raddr     <= '0;
         rlen      <= '0;
         rcnt      <= '0;
         rburst    <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (s_arready && s_arvalid) begin
                  raddr     <= s_araddr[G_ADDR_WIDTH-1:OFST];
                  rlen      <= s_arlen;
                  rburst    <= s_arburst;
                  rcnt      <= '0;
                  s_rid     <= s_arid;
                  s_rresp   <= req_bad(s_arsize, s_arburst, s_arlen) ? SLVERR : OKAY;
                  s_arready <= 1'b0;
                  rstate    <= R_FETCH;
               end else begin
                  s_arready <= 1'b1;
               end
            end
            R_FETCH: begin
               s_rvalid <= 1'b1;
               s_rlast  <= (rlen == 8'd0);
               rstate   <= R_DATA;
            end
            R_DATA: begin
               if (r_hs) begin
                  if (s_rlast) begin
                     s_rvalid  <= 1'b0;
                     s_rlast   <= 1'b0;
                     s_arready <= 1'b1;
                     rstate    <= R_IDLE;
                  end else begin
                     raddr   <= step(raddr, rlen, rburst);
                     rcnt    <= rcnt + 8'd1;
                     s_rlast <= ((rcnt + 8'd1) == rlen);
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   axi4_burst_slave_mem #(
      .AW        (WA),
      .DW        (G_DATA_WIDTH),
      .INIT_FILE (MEM_INIT_FILE)
   ) u_mem (
      .clock (clock),
      .we    (mem_we),
      .waddr (waddr),
      .wdata (s_wdata),
      .raddr (mem_raddr),
      .rdata (s_rdata)
   );

   // Sideband fields and sub-word address bits carry no meaning here.
   logic unused;
   assign unused = ^{s_awlock, s_awcache, s_awprot, s_awqos, s_awaddr,
                     s_arlock, s_arcache, s_arprot, s_arqos, s_araddr};

endmodule
